// File: rtl/decode_pipe_pkg.sv
// Shared types for the RV32 elastic decode stage: opcodes, control selects,
// the decode packet and immediate extraction helpers.
// Latency: n/a (types and pure functions). Backpressure: n/a.
package decode_pipe_pkg;

  // Major opcodes (instr[6:0]) recognised by the decoder.
  typedef enum logic [6:0] {
    OPCODE_LOAD     = 7'h03,
    OPCODE_MISC_MEM = 7'h0f,
    OPCODE_OP_IMM   = 7'h13,
    OPCODE_AUIPC    = 7'h17,
    OPCODE_STORE    = 7'h23,
    OPCODE_OP       = 7'h33,
    OPCODE_LUI      = 7'h37,
    OPCODE_BRANCH   = 7'h63,
    OPCODE_JALR     = 7'h67,
    OPCODE_JAL      = 7'h6f,
    OPCODE_SYSTEM   = 7'h73
  } opcode_e;

  // ALU operations; the comparison ops drive branch resolution.
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
  } alu_op_e;

  // Operand A source. OP_A_IMM is the zero immediate (LUI, FENCE).
  typedef enum logic [1:0] {
    OP_A_REG, OP_A_CURRPC, OP_A_IMM
  } op_a_sel_e;

  typedef enum logic {
    OP_B_REG, OP_B_IMM
  } op_b_sel_e;

  // Immediate source for operand B. IMM_N is the constant 4 used to form
  // the link address (pc + 4) for JAL/JALR, while the packet imm field keeps
  // the jump offset for the PC-ALU.
  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_N
  } imm_b_sel_e;

  typedef enum logic [1:0] {
    PC_NONE, PC_JAL, PC_BRANCH, PC_JALR
  } pc_op_e;

  typedef enum logic [1:0] {
    LSU_BYTE, LSU_HALF, LSU_WORD
  } lsu_size_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_req;
    logic        rs2_req;
    logic        rd_we;
    logic        alu_req;
    alu_op_e     alu_op;
    op_a_sel_e   op_a_sel;
    op_b_sel_e   op_b_sel;
    imm_b_sel_e  imm_b_sel;
    logic        pc_req;
    pc_op_e      pc_op;
    logic        lsu_req;
    logic        lsu_we;
    lsu_size_e   lsu_size;
    logic        lsu_sext;
    logic        illegal;
  } dec_pkt_t;

  // Sign-extended immediates per RV32I instruction format.
  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/decode_pipe_comb.sv
// Combinational RV32I/E decoder: instruction word + pc -> one decode packet.
// Latency: zero cycles (pure combinational). Backpressure: none, stateless.
// Ports: instr/pc in, pkt out. RV32E flags any used register index >= 16.
module decode_comb
  import decode_pipe_pkg::*;
#(
  parameter bit RV32E = 1'b0
) (
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output dec_pkt_t    pkt
);

  opcode_e    opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = opcode_e'(instr[6:0]);
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  dec_pkt_t dec;
  logic     bad_enc;   // unknown opcode or undefined funct3/funct7
  logic     rd_used;   // instruction format carries a destination register
  logic     rv32e_bad;

  always_comb begin
    dec           = '0;
    dec.pc        = pc;
    dec.rs1       = instr[19:15];
    dec.rs2       = instr[24:20];
    dec.rd        = instr[11:7];
    bad_enc       = 1'b0;
    rd_used       = 1'b0;
    rv32e_bad     = 1'b0;

    case (opcode)
      OPCODE_LOAD: begin
        dec.rs1_req   = 1'b1;
        rd_used       = 1'b1;
        dec.lsu_req   = 1'b1;
        dec.imm       = imm_i(instr);
        dec.imm_b_sel = IMM_I;
        case (funct3)
          3'b000: begin dec.lsu_size = LSU_BYTE; dec.lsu_sext = 1'b1; end
          3'b001: begin dec.lsu_size = LSU_HALF; dec.lsu_sext = 1'b1; end
          3'b010: dec.lsu_size = LSU_WORD;
          3'b100: dec.lsu_size = LSU_BYTE;
          3'b101: dec.lsu_size = LSU_HALF;
          default: bad_enc = 1'b1;
        endcase
      end

      OPCODE_STORE: begin
        dec.rs1_req   = 1'b1;
        dec.rs2_req   = 1'b1;
        dec.lsu_req   = 1'b1;
        dec.lsu_we    = 1'b1;
        dec.imm       = imm_s(instr);
        dec.imm_b_sel = IMM_S;
        case (funct3)
          3'b000: dec.lsu_size = LSU_BYTE;
          3'b001: dec.lsu_size = LSU_HALF;
          3'b010: dec.lsu_size = LSU_WORD;
          default: bad_enc = 1'b1;
        endcase
      end

      OPCODE_JAL: begin
        // ALU forms the link address pc+4; PC-ALU uses the J offset.
        rd_used       = 1'b1;
        dec.alu_req   = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.op_a_sel  = OP_A_CURRPC;
        dec.op_b_sel  = OP_B_IMM;
        dec.imm_b_sel = IMM_N;
        dec.pc_req    = 1'b1;
        dec.pc_op     = PC_JAL;
        dec.imm       = imm_j(instr);
      end

      OPCODE_JALR: begin
        dec.rs1_req   = 1'b1;
        rd_used       = 1'b1;
        dec.alu_req   = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.op_a_sel  = OP_A_CURRPC;
        dec.op_b_sel  = OP_B_IMM;
        dec.imm_b_sel = IMM_N;
        dec.pc_req    = 1'b1;
        dec.pc_op     = PC_JALR;
        dec.imm       = imm_i(instr);
        bad_enc       = (funct3 != 3'b000);
      end

      OPCODE_BRANCH: begin
        // ALU evaluates the condition on rs1/rs2; PC-ALU adds the B offset.
        dec.rs1_req   = 1'b1;
        dec.rs2_req   = 1'b1;
        dec.alu_req   = 1'b1;
        dec.op_a_sel  = OP_A_REG;
        dec.op_b_sel  = OP_B_REG;
        dec.imm_b_sel = IMM_B;
        dec.pc_req    = 1'b1;
        dec.pc_op     = PC_BRANCH;
        dec.imm       = imm_b(instr);
        case (funct3)
          3'b000: dec.alu_op = ALU_EQ;
          3'b001: dec.alu_op = ALU_NE;
          3'b100: dec.alu_op = ALU_LT;
          3'b101: dec.alu_op = ALU_GE;
          3'b110: dec.alu_op = ALU_LTU;
          3'b111: dec.alu_op = ALU_GEU;
          default: bad_enc = 1'b1;
        endcase
      end

      OPCODE_LUI: begin
        rd_used       = 1'b1;
        dec.alu_req   = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.op_a_sel  = OP_A_IMM;
        dec.op_b_sel  = OP_B_IMM;
        dec.imm_b_sel = IMM_U;
        dec.imm       = imm_u(instr);
      end

      OPCODE_AUIPC: begin
        rd_used       = 1'b1;
        dec.alu_req   = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.op_a_sel  = OP_A_CURRPC;
        dec.op_b_sel  = OP_B_IMM;
        dec.imm_b_sel = IMM_U;
        dec.imm       = imm_u(instr);
      end

      OPCODE_OP_IMM: begin
        dec.rs1_req   = 1'b1;
        rd_used       = 1'b1;
        dec.alu_req   = 1'b1;
        dec.op_a_sel  = OP_A_REG;
        dec.op_b_sel  = OP_B_IMM;
        dec.imm_b_sel = IMM_I;
        dec.imm       = imm_i(instr);
        case (funct3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b010: dec.alu_op = ALU_SLT;
          3'b011: dec.alu_op = ALU_SLTU;
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b001: begin
            // RV32 shamt is 5 bits, so instr[25] must be clear too.
            dec.alu_op = ALU_SLL;
            bad_enc    = (funct7 != 7'b0000000);
          end
          3'b101: begin
            if (funct7 == 7'b0000000) begin
              dec.alu_op = ALU_SRL;
            end else if (funct7 == 7'b0100000) begin
              dec.alu_op = ALU_SRA;
            end else begin
              bad_enc = 1'b1;
            end
          end
          default: bad_enc = 1'b1;
        endcase
      end

      OPCODE_OP: begin
        dec.rs1_req  = 1'b1;
        dec.rs2_req  = 1'b1;
        rd_used      = 1'b1;
        dec.alu_req  = 1'b1;
        dec.op_a_sel = OP_A_REG;
        dec.op_b_sel = OP_B_REG;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: dec.alu_op = ALU_ADD;
            3'b001: dec.alu_op = ALU_SLL;
            3'b010: dec.alu_op = ALU_SLT;
            3'b011: dec.alu_op = ALU_SLTU;
            3'b100: dec.alu_op = ALU_XOR;
            3'b101: dec.alu_op = ALU_SRL;
            3'b110: dec.alu_op = ALU_OR;
            default: dec.alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec.alu_op = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec.alu_op = ALU_SRA;
        end else begin
          bad_enc = 1'b1;
        end
      end

      OPCODE_MISC_MEM: begin
        // FENCE is a NOP here: 0 + 0 into nowhere, keeps the slot in order.
        dec.alu_req   = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.op_a_sel  = OP_A_IMM;
        dec.op_b_sel  = OP_B_IMM;
        dec.imm_b_sel = IMM_I;
        dec.imm       = 32'h0;
        bad_enc       = (funct3 != 3'b000);
      end

      default: bad_enc = 1'b1;  // SYSTEM and unknown opcodes
    endcase

    dec.rd_we = rd_used && (dec.rd != 5'd0);

    if (RV32E) begin
      rv32e_bad = (dec.rs1_req && dec.rs1[4]) ||
                  (dec.rs2_req && dec.rs2[4]) ||
                  (rd_used     && dec.rd[4]);
    end

    // Illegal packets keep only pc and the flag so they stay in order but
    // cannot trigger any register, ALU, PC or memory side effect.
    if (bad_enc || rv32e_bad || (instr[1:0] != 2'b11)) begin
      dec         = '0;
      dec.pc      = pc;
      dec.illegal = 1'b1;
    end
  end

  assign pkt = dec;

endmodule

// File: rtl/decode_pipe.sv
// Elastic RV32 decode stage: decodes each accepted instruction into a FIFO.
// Latency: 1 cycle from accept to dec_valid_o when the FIFO is empty.
// Backpressure: instr_ready_o = !full (registered state only); flush wins.
// Ports: clk_i/rst_ni; flush_i; instr_valid_i/instr_ready_o/instr_rdata_i/
//        instr_pc_i in; dec_valid_o/dec_ready_i/dec_pkt_o out; illegal_cnt_o.
module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 2,     // FIFO entries, 1..4
  parameter bit          RV32E = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_rdata_i,
  input  logic [31:0] instr_pc_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output dec_pkt_t    dec_pkt_o,
  output logic [15:0] illegal_cnt_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  dec_pkt_t        dec_new;
  dec_pkt_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [15:0]     illegal_cnt;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  decode_comb #(
    .RV32E (RV32E)
  ) u_decode_comb (
    .instr (instr_rdata_i),
    .pc    (instr_pc_i),
    .pkt   (dec_new)
  );

  // Full/empty come straight from the count register, so ready never
  // depends combinationally on dec_ready_i.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = instr_valid_i && !full && !flush_i;
  assign pop   = !empty && dec_ready_i && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while count covers them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= dec_new;
    end
  end

  // Counts only accepted illegal packets; a push dropped by flush never counts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_cnt <= '0;
    end else if (push && dec_new.illegal && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end

  assign instr_ready_o = !full;
  assign dec_valid_o   = !empty;
  assign dec_pkt_o     = empty ? '0 : mem[rd_ptr];
  assign illegal_cnt_o = illegal_cnt;

endmodule

// File: tb/tb_decode_pipe.sv
module tb_decode_pipe;
  import decode_pipe_pkg::*;

  logic        clk_i;
  logic        rst_ni;
  logic        flush_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_rdata_i;
  logic [31:0] instr_pc_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  dec_pkt_t    pkt;
  logic [15:0] illegal_cnt_o;

  int nvec = 0;
  int nerr = 0;

  decode_pipe #(
    .DEPTH (2),
    .RV32E (1'b1)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_rdata_i (instr_rdata_i),
    .instr_pc_i    (instr_pc_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_pkt_o     (pkt),
    .illegal_cnt_o (illegal_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkp(input string tag, input dec_pkt_t obs, input dec_pkt_t exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Offer one instruction for exactly one edge.
  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    instr_valid_i = 1'b1;
    instr_rdata_i = ins;
    instr_pc_i    = pc;
    tick();
    instr_valid_i = 1'b0;
  endtask

  task automatic pop1();
    dec_ready_i = 1'b1;
    tick();
    dec_ready_i = 1'b0;
  endtask

  dec_pkt_t e;

  initial begin
    rst_ni        = 1'b0;
    flush_i       = 1'b0;
    instr_valid_i = 1'b0;
    instr_rdata_i = '0;
    instr_pc_i    = '0;
    dec_ready_i   = 1'b0;
    #12 rst_ni = 1'b1;
    #1;

    // Reset state
    chk("rst_valid", 32'(dec_valid_o), 32'd0);
    chk("rst_ready", 32'(instr_ready_o), 32'd1);
    chk("rst_cnt", 32'(illegal_cnt_o), 32'd0);
    chkp("rst_pkt", pkt, '0);

    // addi x1,x0,5
    push(32'h00500093, 32'h100);
    chk("addi_valid", 32'(dec_valid_o), 32'd1);
    chk("addi_pc", pkt.pc, 32'h100);
    chk("addi_rs1", 32'(pkt.rs1), 32'd0);
    chk("addi_rd", 32'(pkt.rd), 32'd1);
    chk("addi_rd_we", 32'(pkt.rd_we), 32'd1);
    chk("addi_imm", pkt.imm, 32'h5);
    chk("addi_alu_op", 32'(pkt.alu_op), 32'(ALU_ADD));
    chk("addi_op_b", 32'(pkt.op_b_sel), 32'(OP_B_IMM));
    chk("addi_imm_sel", 32'(pkt.imm_b_sel), 32'(IMM_I));
    chk("addi_illegal", 32'(pkt.illegal), 32'd0);
    pop1();
    chk("addi_drained", 32'(dec_valid_o), 32'd0);

    // jalr x1,4(x2) then beq x1,x2,-8, queued back to back
    push(32'h004100E7, 32'h110);
    push(32'hFE208CE3, 32'h114);
    chk("jalr_pc_req", 32'(pkt.pc_req), 32'd1);
    chk("jalr_pc_op", 32'(pkt.pc_op), 32'(PC_JALR));
    chk("jalr_rs1", 32'(pkt.rs1), 32'd2);
    chk("jalr_rs1_req", 32'(pkt.rs1_req), 32'd1);
    chk("jalr_imm", pkt.imm, 32'd4);
    chk("jalr_op_a", 32'(pkt.op_a_sel), 32'(OP_A_CURRPC));
    chk("jalr_imm_sel", 32'(pkt.imm_b_sel), 32'(IMM_N));
    chk("jalr_rd", 32'(pkt.rd), 32'd1);
    chk("jalr_rd_we", 32'(pkt.rd_we), 32'd1);
    pop1();
    chk("beq_pc", pkt.pc, 32'h114);
    chk("beq_imm", pkt.imm, 32'hFFFFFFF8);
    chk("beq_alu_op", 32'(pkt.alu_op), 32'(ALU_EQ));
    chk("beq_rd_we", 32'(pkt.rd_we), 32'd0);
    chk("beq_pc_op", 32'(pkt.pc_op), 32'(PC_BRANCH));
    pop1();
    chk("beq_drained", 32'(dec_valid_o), 32'd0);

    // Fill DEPTH=2 with three back-to-back offers, then drain in order
    instr_valid_i = 1'b1;
    instr_rdata_i = 32'h00100093; instr_pc_i = 32'h120;  // addi x1,x0,1
    tick();
    chk("fill1_ready", 32'(instr_ready_o), 32'd1);
    instr_rdata_i = 32'h00200113; instr_pc_i = 32'h124;  // addi x2,x0,2
    tick();
    chk("fill2_ready", 32'(instr_ready_o), 32'd0);
    instr_rdata_i = 32'h00300193; instr_pc_i = 32'h128;  // addi x3,x0,3
    tick();
    chk("stall_ready", 32'(instr_ready_o), 32'd0);
    chk("stall_head_imm", pkt.imm, 32'd1);
    chk("stall_head_pc", pkt.pc, 32'h120);
    dec_ready_i = 1'b1;
    tick();
    chk("drain1_ready", 32'(instr_ready_o), 32'd1);
    chk("drain1_imm", pkt.imm, 32'd2);
    tick();
    instr_valid_i = 1'b0;
    chk("drain2_valid", 32'(dec_valid_o), 32'd1);
    chk("drain2_imm", pkt.imm, 32'd3);
    chk("drain2_pc", pkt.pc, 32'h128);
    tick();
    dec_ready_i = 1'b0;
    chk("drain3_valid", 32'(dec_valid_o), 32'd0);

    // Full FIFO + offered push + pop, all overridden by flush
    push(32'h00100093, 32'h130);
    push(32'h00200113, 32'h134);
    instr_valid_i = 1'b1;
    instr_rdata_i = 32'h00300193;
    instr_pc_i    = 32'h138;
    dec_ready_i   = 1'b1;
    flush_i       = 1'b1;
    tick();
    flush_i       = 1'b0;
    instr_valid_i = 1'b0;
    dec_ready_i   = 1'b0;
    chk("flush_valid", 32'(dec_valid_o), 32'd0);
    chk("flush_ready", 32'(instr_ready_o), 32'd1);
    chkp("flush_pkt", pkt, '0);
    tick();
    chk("flush_stale", 32'(dec_valid_o), 32'd0);

    // A push dropped by flush is not counted as illegal
    instr_valid_i = 1'b1;
    instr_rdata_i = 32'hFFFFFFFF;
    flush_i       = 1'b1;
    tick();
    flush_i       = 1'b0;
    instr_valid_i = 1'b0;
    chk("flush_cnt", 32'(illegal_cnt_o), 32'd0);
    chk("flush_drop_valid", 32'(dec_valid_o), 32'd0);

    // Illegal encodings: all-ones word, then add x17 under RV32E
    push(32'hFFFFFFFF, 32'h200);
    push(32'h002088B3, 32'h204);
    chk("ill_cnt", 32'(illegal_cnt_o), 32'd2);
    e = '0; e.pc = 32'h200; e.illegal = 1'b1;
    chkp("ill_pkt1", pkt, e);
    pop1();
    e = '0; e.pc = 32'h204; e.illegal = 1'b1;
    chkp("ill_pkt2", pkt, e);
    pop1();

    // Reset with two entries buffered clears asynchronously
    push(32'h00100093, 32'h210);
    push(32'h00200113, 32'h214);
    chk("pre_rst_valid", 32'(dec_valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", 32'(dec_valid_o), 32'd0);
    chk("async_rst_ready", 32'(instr_ready_o), 32'd1);
    chk("async_rst_cnt", 32'(illegal_cnt_o), 32'd0);
    #10 rst_ni = 1'b1;
    tick();
    chk("post_rst_valid", 32'(dec_valid_o), 32'd0);

    // lw x2,0(x1)
    push(32'h0000A103, 32'h300);
    chk("lw_valid", 32'(dec_valid_o), 32'd1);
    chk("lw_size", 32'(pkt.lsu_size), 32'(LSU_WORD));
    chk("lw_req", 32'(pkt.lsu_req), 32'd1);
    chk("lw_we", 32'(pkt.lsu_we), 32'd0);
    chk("lw_sext", 32'(pkt.lsu_sext), 32'd0);
    chk("lw_rd", 32'(pkt.rd), 32'd2);
    pop1();

    // lb x3,0(x1) sign-extends; srli with upper field 0010000 is illegal
    push(32'h00008183, 32'h304);
    chk("lb_size", 32'(pkt.lsu_size), 32'(LSU_BYTE));
    chk("lb_sext", 32'(pkt.lsu_sext), 32'd1);
    pop1();
    push(32'h2010D093, 32'h308);
    chk("badsrl_illegal", 32'(pkt.illegal), 32'd1);
    chk("badsrl_cnt", 32'(illegal_cnt_o), 32'd1);
    pop1();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
